// File: rtl/rob_complete_if.sv
// ==============================================================================
// rob_complete_if -- dispatch / completion / retire bundle of the ROB | rev 1.0
// ==============================================================================
`default_nettype none

interface rob_complete_if #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
);
   logic                 i_flush;
   logic                 i_alloc_valid;
   logic [4:0]           i_alloc_rd;
   logic                 i_alloc_wb;
   logic                 o_alloc_ready;
   logic [TAG_W-1:0]     o_alloc_tag;
   logic [2:0]           i_cmp_valid;
   logic [3*TAG_W-1:0]   i_cmp_tag;
   logic [3*XLEN-1:0]    i_cmp_result;
   logic [1:0]           o_ret_valid;
   logic [1:0]           o_ret_we;
   logic [9:0]           o_ret_rd;
   logic [2*XLEN-1:0]    o_ret_data;
   logic [2*TAG_W-1:0]   o_ret_tag;
   logic [TAG_W:0]       o_count;
   logic                 o_empty;
   logic                 o_full;
   logic                 o_cmp_err;

   modport master (
      output i_flush, i_alloc_valid, i_alloc_rd, i_alloc_wb,
      output i_cmp_valid, i_cmp_tag, i_cmp_result,
      input  o_alloc_ready, o_alloc_tag,
      input  o_ret_valid, o_ret_we, o_ret_rd, o_ret_data, o_ret_tag,
      input  o_count, o_empty, o_full, o_cmp_err
   );

   modport slave (
      input  i_flush, i_alloc_valid, i_alloc_rd, i_alloc_wb,
      input  i_cmp_valid, i_cmp_tag, i_cmp_result,
      output o_alloc_ready, o_alloc_tag,
      output o_ret_valid, o_ret_we, o_ret_rd, o_ret_data, o_ret_tag,
      output o_count, o_empty, o_full, o_cmp_err
   );
endinterface

`default_nettype wire

// File: rtl/rob_complete.sv
// ==============================================================================
// rob_complete -- in-order ROB, 3 out-of-order completion lanes, 2-wide retire | rev 1.0
// ==============================================================================
`default_nettype none

module rob_complete #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   rob_complete_if.slave   bus
);

   localparam int LANES = 3;

   // entry state
   logic [DEPTH-1:0]  ent_valid;
   logic [DEPTH-1:0]  ent_done;
   logic [DEPTH-1:0]  ent_wb;
   logic [4:0]        ent_rd   [DEPTH];
   logic [XLEN-1:0]   ent_data [DEPTH];

   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [TAG_W:0]    count;

   // registered retire outputs
   logic [1:0]        ret_valid;
   logic [1:0]        ret_we;
   logic [9:0]        ret_rd;
   logic [2*XLEN-1:0] ret_data;
   logic [2*TAG_W-1:0] ret_tag;
   logic              cmp_err;

   // combinational control
   logic              alloc_ready;
   logic              alloc_fire;
   logic [TAG_W-1:0]  lane_tag [LANES];
   logic [XLEN-1:0]   lane_res [LANES];
   logic [LANES-1:0]  lane_dup;
   logic [LANES-1:0]  lane_ok;
   logic              cmp_err_set;
   logic [DEPTH-1:0]  cmp_hit;
   logic [XLEN-1:0]   cmp_wdata [DEPTH];
   logic [TAG_W-1:0]  head1;
   logic              ret0;
   logic              ret1;
   logic [1:0]        n_ret;

   // Allocation looks only at the registered count, so a full ROB stays closed
   // even when a retire frees a slot in the same cycle.
   assign alloc_ready = (count < (TAG_W+1)'(DEPTH));
   assign alloc_fire  = bus.i_alloc_valid && alloc_ready;

   always_comb begin
      for (int n = 0; n < LANES; n++) begin
         lane_tag[n] = bus.i_cmp_tag[n*TAG_W +: TAG_W];
         lane_res[n] = bus.i_cmp_result[n*XLEN +: XLEN];
      end
   end

   // A lane loses to any lower-numbered lane presenting the same tag.
   always_comb begin
      lane_dup    = '0;
      lane_ok     = '0;
      cmp_err_set = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         for (int m = 0; m < n; m++) begin
            if (bus.i_cmp_valid[m] && (lane_tag[m] == lane_tag[n])) begin
               lane_dup[n] = 1'b1;
            end
         end
         lane_ok[n] = bus.i_cmp_valid[n] && !lane_dup[n] &&
                      ent_valid[lane_tag[n]] && !ent_done[lane_tag[n]];
         if (bus.i_cmp_valid[n] && !lane_ok[n]) begin
            cmp_err_set = 1'b1;
         end
      end
   end

   always_comb begin
      cmp_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cmp_wdata[i] = '0;
         for (int n = 0; n < LANES; n++) begin
            if (lane_ok[n] && (lane_tag[n] == TAG_W'(i))) begin
               cmp_hit[i]   = 1'b1;
               cmp_wdata[i] = lane_res[n];
            end
         end
      end
   end

   // done is only visible from the registered bit, so a completion retires one cycle later at the earliest.
   assign head1 = head + TAG_W'(1);
   assign ret0  = ent_valid[head] && ent_done[head];
   assign ret1  = ret0 && ent_valid[head1] && ent_done[head1];
   assign n_ret = {1'b0, ret0} + {1'b0, ret1};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_done  <= '0;
         ret_valid <= '0;
         ret_we    <= '0;
         ret_rd    <= '0;
         ret_data  <= '0;
         ret_tag   <= '0;
         cmp_err   <= 1'b0;
      end else if (bus.i_flush) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_done  <= '0;
         ret_valid <= '0;
         ret_we    <= '0;
         ret_rd    <= '0;
         ret_data  <= '0;
         ret_tag   <= '0;
      end else begin
         head    <= head + TAG_W'(n_ret);
         count   <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(n_ret);
         cmp_err <= cmp_err | cmp_err_set;
         if (alloc_fire) begin
            tail <= tail + TAG_W'(1);
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (cmp_hit[i]) begin
               ent_done[i] <= 1'b1;
            end
            if (alloc_fire && (tail == TAG_W'(i))) begin
               ent_valid[i] <= 1'b1;
               ent_done[i]  <= 1'b0;
            end
            if ((ret0 && (head == TAG_W'(i))) || (ret1 && (head1 == TAG_W'(i)))) begin
               ent_valid[i] <= 1'b0;
               ent_done[i]  <= 1'b0;
            end
         end
         ret_valid <= {ret1, ret0};
         ret_we    <= {ret1 && ent_wb[head1] && (ent_rd[head1] != 5'd0),
                       ret0 && ent_wb[head]  && (ent_rd[head]  != 5'd0)};
         ret_rd    <= {ret1 ? ent_rd[head1]   : 5'd0,
                       ret0 ? ent_rd[head]    : 5'd0};
         ret_data  <= {ret1 ? ent_data[head1] : {XLEN{1'b0}},
                       ret0 ? ent_data[head]  : {XLEN{1'b0}}};
         ret_tag   <= {ret1 ? head1 : {TAG_W{1'b0}},
                       ret0 ? head  : {TAG_W{1'b0}}};
      end
   end

   // Payload storage needs no reset: it is only read behind valid/done.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_fire && (tail == TAG_W'(i))) begin
            ent_wb[i] <= bus.i_alloc_wb;
            ent_rd[i] <= bus.i_alloc_rd;
         end
         if (cmp_hit[i]) begin
            ent_data[i] <= cmp_wdata[i];
         end
      end
   end

   assign bus.o_alloc_ready = alloc_ready;
   assign bus.o_alloc_tag   = tail;
   assign bus.o_ret_valid   = ret_valid;
   assign bus.o_ret_we      = ret_we;
   assign bus.o_ret_rd      = ret_rd;
   assign bus.o_ret_data    = ret_data;
   assign bus.o_ret_tag     = ret_tag;
   assign bus.o_count       = count;
   assign bus.o_empty       = (count == '0);
   assign bus.o_full        = (count == (TAG_W+1)'(DEPTH));
   assign bus.o_cmp_err     = cmp_err;

endmodule

`default_nettype wire
